// File: rtl/accel_cmd_sched_pkg.sv
// Package: accel_cmd_sched_pkg
// Purpose : Shared definitions for the Accel command scheduler: the
//           instruction width, default cycle constants, the phase counter
//           width and the FSM state encoding.
// Ports   : none (package).
package accel_cmd_sched_pkg;

  localparam int ACCEL_INSTR_W        = 32;
  localparam int DEF_FIFO_DEPTH       = 4;
  localparam int DEF_RST_CYCLES       = 2;
  localparam int DEF_SETTLE_CYCLES    = 10;
  localparam int DEF_TIMEOUT_CYCLES   = 65535;
  localparam int CNT_W                = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_RETIRE = 3'd4
  } state_t;

endpackage

// File: rtl/accel_cmd_sched_fifo.sv
// Module : accel_cmd_sched_fifo
// Purpose: Synchronous command FIFO. The head entry is shown on dout
//          combinationally so the scheduler can load it in the pop cycle.
// Ports  : clk, rst (sync, active-high), push, pop, din[WIDTH], dout[WIDTH],
//          full, empty.
//          A push while full and a pop while empty are ignored; a
//          simultaneous push and pop leave the occupancy unchanged.
module accel_cmd_sched_fifo
  import accel_cmd_sched_pkg::*;
#(
  parameter int WIDTH = ACCEL_INSTR_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers are log2(DEPTH) bits wide, so they wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/accel_cmd_sched.sv
// Module : accel_cmd_sched
// Purpose: Queues 32-bit instructions from the CPU and issues them to Accel
//          one at a time: hold Accel in reset while the instruction is
//          loaded, release it, wait for accel_done, wait a settle window,
//          then retire the command with a one-cycle irq.
// Ports  : clk, rst_ext (sync, active-high)
//          cmd_valid, cmd_data[32], cmd_ready     CPU command push
//          accel_instruction[32], accel_rst, accel_done   Accel side
//          busy, irq, retire_count[16], timeout_err     status
// Handshake: a command is pushed on any cycle with cmd_valid & cmd_ready;
//          cmd_ready is ~full from registered occupancy, so a freed slot
//          shows on cmd_ready one cycle after the pop.
// Option : define ACCEL_SCHED_TIMEOUT_EN to enable the RUN-state watchdog
//          (TIMEOUT_CYCLES); otherwise RUN waits forever and timeout_err=0.
module accel_cmd_sched
  import accel_cmd_sched_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_ext,
  input  logic                     cmd_valid,
  input  logic [ACCEL_INSTR_W-1:0] cmd_data,
  output logic                     cmd_ready,
  output logic [ACCEL_INSTR_W-1:0] accel_instruction,
  output logic                     accel_rst,
  input  logic                     accel_done,
  output logic                     busy,
  output logic                     irq,
  output logic [15:0]              retire_count,
  output logic                     timeout_err
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [ACCEL_INSTR_W-1:0] fifo_dout;
  logic                     go_retire;
  logic                     timeout_hit;

  accel_cmd_sched_fifo #(
    .WIDTH (ACCEL_INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst_ext),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .din   (cmd_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = ~fifo_full;
  assign busy      = (state != S_IDLE) | ~fifo_empty;
  // The head is taken from IDLE, and from RETIRE for back-to-back issue.
  assign fifo_pop  = ~fifo_empty & ((state == S_IDLE) | (state == S_RETIRE));

`ifdef ACCEL_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // A done seen in the same cycle as the limit still counts as completion.
  assign timeout_hit = (state == S_RUN) && !accel_done && (cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst_ext) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    go_retire = 1'b0;
    if (state == S_RUN) begin
      go_retire = (accel_done && (SETTLE_CYCLES == 0)) || timeout_hit;
    end else if (state == S_SETTLE) begin
      go_retire = (cnt == SETTLE_LAST);
    end
  end

  // accel_rst is registered alongside the state: high in IDLE/LOAD/RETIRE,
  // low in RUN/SETTLE.
  always_ff @(posedge clk) begin
    if (rst_ext) begin
      state             <= S_IDLE;
      cnt               <= '0;
      accel_instruction <= '0;
      accel_rst         <= 1'b1;
      irq               <= 1'b0;
      retire_count      <= '0;
    end else begin
      irq <= 1'b0;
      if (go_retire) begin
        state        <= S_RETIRE;
        cnt          <= '0;
        accel_rst    <= 1'b1;
        irq          <= 1'b1;
        retire_count <= retire_count + 16'd1;
      end else begin
        case (state)
          S_IDLE: begin
            if (!fifo_empty) begin
              accel_instruction <= fifo_dout;
              cnt               <= '0;
              state             <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (cnt == RST_LAST) begin
              cnt       <= '0;
              accel_rst <= 1'b0;
              state     <= S_RUN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RUN: begin
            // cnt doubles as the watchdog count while running.
            if (accel_done) begin
              cnt   <= '0;
              state <= S_SETTLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_SETTLE: begin
            cnt <= cnt + 1'b1;
          end
          S_RETIRE: begin
            if (!fifo_empty) begin
              accel_instruction <= fifo_dout;
              cnt               <= '0;
              state             <= S_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end
          default: begin
            state     <= S_IDLE;
            accel_rst <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
